// File: rtl/core_avl_ram_slave_if.sv
// Avalon-style memory bus between an LSU master and a memory responder.
interface i_avl_bus;
    logic [31:0] address;
    logic [3:0]  byte_en;
    logic        read;
    logic        write;
    logic [31:0] write_data;
    logic        waitrequest;
    logic [31:0] read_data;
    logic        read_data_valid;

    modport slave (
        input  address, byte_en, read, write, write_data,
        output waitrequest, read_data, read_data_valid
    );

    modport master (
        output address, byte_en, read, write, write_data,
        input  waitrequest, read_data, read_data_valid
    );
endinterface

// File: rtl/core_avl_ram_slave.sv
// Single-ported word RAM behind an Avalon-style slave port.
// Commands accept after WAIT_CYCLES wait states, and reads return one cycle after acceptance.
module core_avl_ram_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter string       INIT_FILE   = ""
) (
    input logic     clk,
    input logic     rest,
    i_avl_bus.slave avl_s0
);

    localparam int unsigned AW     = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN   = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  WAIT_N = 4'(WAIT_CYCLES);

    logic [31:0]   mem [DEPTH_WORDS];
    logic [3:0]    cnt;
    logic          req;
    logic          wait_c;
    logic          accept;
    logic          in_range;
    logic [31:0]   offset;
    logic [AW-1:0] idx;
    logic [31:0]   rdata_q;
    logic          rvalid_q;

    // Request qualification, wait-state stall and address decode
    always_comb begin
        req      = avl_s0.read | avl_s0.write;
        wait_c   = !rest | (req && (cnt != WAIT_N));
        accept   = req && !wait_c;
        offset   = avl_s0.address - BASE_ADDR;
        idx      = offset[AW+1:2];
        in_range = (avl_s0.address >= BASE_ADDR) && ({1'b0, offset} < SPAN);
    end

    assign avl_s0.waitrequest     = wait_c;
    assign avl_s0.read_data       = rdata_q;
    assign avl_s0.read_data_valid = rvalid_q;

    // Wait-state counter and read response; write wins when both strobes are high
    always_ff @(posedge clk) begin
        if (!rest) begin
            cnt      <= 4'd0;
            rvalid_q <= 1'b0;
            rdata_q  <= 32'h0;
        end else begin
            if (!req || accept) begin
                cnt <= 4'd0;
            end else if (cnt < WAIT_N) begin
                cnt <= cnt + 4'd1;
            end
            rvalid_q <= accept && avl_s0.read && !avl_s0.write;
            if (accept && avl_s0.read && !avl_s0.write) begin
                rdata_q <= in_range ? mem[idx] : 32'h0;
            end
        end
    end

    // Byte-lane masked write; the array itself is never reset
    always_ff @(posedge clk) begin
        if (accept && avl_s0.write && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (avl_s0.byte_en[b]) begin
                    mem[idx][8*b +: 8] <= avl_s0.write_data[8*b +: 8];
                end
            end
        end
    end

endmodule
